// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: drives PC controls, runs the imem request/ack
// handshake, buffers one instruction for decode, applies execute redirects
// and flags a memory that never acknowledges.
module fetch_controller #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    output logic        pc_write,
    output logic        pc_source,
    output logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        id_ready,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    output logic        fetch_error
);

    localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_HOLD  = 3'd2,
        S_DRAIN = 3'd3,
        S_ERROR = 3'd4
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic [31:0]      drain_addr;

    logic             redirect_ok;
    logic             consume;
    logic [CNT_W-1:0] wait_inc;
    logic             wait_limit;

    // Redirects are honoured everywhere except the terminal error state
    assign redirect_ok = redirect && (state != S_ERROR);
    assign consume     = if_valid && id_ready && !stall;

    // Saturating increment keeps a redirect-extended wait from wrapping
    assign wait_inc   = (wait_cnt == CNT_W'(MAX_WAIT)) ? wait_cnt : wait_cnt + CNT_W'(1);
    // True on the MAX_WAIT-th consecutive cycle without an acknowledge
    assign wait_limit = (wait_cnt >= CNT_W'(MAX_WAIT - 1));

    // PC control and memory request, combinational from state and inputs
    always_comb begin
        pc_write      = 1'b0;
        pc_source     = 1'b0;
        branch_target = 32'd0;
        imem_req      = 1'b0;
        imem_addr     = 32'd0;
        if (!reset) begin
            case (state)
                S_FETCH: begin
                    imem_req  = 1'b1;
                    imem_addr = pc;
                    if (imem_ack) begin
                        pc_write = 1'b1;
                    end
                end
                S_DRAIN: begin
                    imem_req  = 1'b1;
                    imem_addr = drain_addr;
                end
                default: begin
                end
            endcase
            if (redirect_ok) begin
                pc_write      = 1'b1;
                pc_source     = 1'b1;
                branch_target = redirect_target;
            end
        end
    end

    // Sequencer state, watchdog and registered fetch-buffer outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            if_valid    <= 1'b0;
            if_instr    <= 32'd0;
            if_pc       <= 32'd0;
            fetch_error <= 1'b0;
            wait_cnt    <= '0;
            drain_addr  <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    state    <= S_FETCH;
                    wait_cnt <= '0;
                    if_valid <= 1'b0;
                end

                S_FETCH: begin
                    if (redirect) begin
                        if_valid <= 1'b0;
                        if (imem_ack) begin
                            // Returning data belongs to the squashed path
                            wait_cnt <= '0;
                            state    <= S_FETCH;
                        end else begin
                            // Keep the outstanding request stable until it completes
                            drain_addr <= pc;
                            wait_cnt   <= wait_inc;
                            state      <= S_DRAIN;
                        end
                    end else if (imem_ack) begin
                        if_instr <= imem_rdata;
                        if_pc    <= pc;
                        if_valid <= 1'b1;
                        wait_cnt <= '0;
                        state    <= S_HOLD;
                    end else if (wait_limit) begin
                        wait_cnt    <= wait_inc;
                        if_valid    <= 1'b0;
                        fetch_error <= 1'b1;
                        state       <= S_ERROR;
                    end else begin
                        wait_cnt <= wait_inc;
                    end
                end

                S_DRAIN: begin
                    if (redirect) begin
                        if_valid <= 1'b0;
                    end
                    if (imem_ack) begin
                        wait_cnt <= '0;
                        state    <= S_FETCH;
                    end else if (!redirect && wait_limit) begin
                        wait_cnt    <= wait_inc;
                        if_valid    <= 1'b0;
                        fetch_error <= 1'b1;
                        state       <= S_ERROR;
                    end else begin
                        wait_cnt <= wait_inc;
                    end
                end

                S_HOLD: begin
                    // A redirect flushes the buffer even under stall
                    if (redirect || consume) begin
                        if_valid <= 1'b0;
                        wait_cnt <= '0;
                        state    <= S_FETCH;
                    end
                end

                S_ERROR: begin
                    fetch_error <= 1'b1;
                    if_valid    <= 1'b0;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
